axi_mm_master_name_reg: RTL and testbench
=========================================

// Module: axi_mm_master_name_reg
// PURPOSE
//  Master-side AXI4-MM <-> logic-link bridge, AIB far end of the slave-side name mapper.
//  Packs user AR/AW/W into txfifo words and unpacks rxfifo R/B words onto user AXI.
//  Every channel passes through a 2-entry skid buffer, so all outputs are registered.
//  Outstanding reads and writes are capped so the far-end slave FIFOs cannot overrun.
// PARAMETERS
//  MAX_RD_OUT  8  max accepted ARs whose RLAST beat has not yet handshaken (1..255)
//  MAX_WR_OUT  8  max accepted AWs whose B has not yet handshaken (1..255)
// PORTS
//  clk_wr          in   1   single clock, all logic on rising edge
//  rst_wr_n        in   1   synchronous, active-low reset
//  user_ar{id,size,len,burst,addr}  in  2/3/8/2/32  AR fields from user master
//  user_arvalid / user_arready      in/out  1  AR handshake (user side)
//  user_aw{id,size,len,burst,addr}  in  2/3/8/2/32  AW fields from user master
//  user_awvalid / user_awready      in/out  1  AW handshake (user side)
//  user_w{id,data,strb,last}        in  2/32/4/1  W fields from user master
//  user_wvalid / user_wready        in/out  1  W handshake (user side)
//  user_r{id,data,last,resp}        out 2/32/1/2  R fields to user master
//  user_rvalid / user_rready        out/in  1  R handshake (user side)
//  user_b{id,resp}                  out 2/2  B fields to user master
//  user_bvalid / user_bready        out/in  1  B handshake (user side)
//  user_ar_vld/txfifo_ar_data/user_ar_ready  out/out/in  1/47/1  AR link word
//  user_aw_vld/txfifo_aw_data/user_aw_ready  out/out/in  1/47/1  AW link word
//  user_w_vld /txfifo_w_data /user_w_ready   out/out/in  1/39/1  W link word
//  user_r_vld /rxfifo_r_data /user_r_ready   in/in/out   1/37/1  R link word
//  user_b_vld /rxfifo_b_data /user_b_ready   in/in/out   1/4/1   B link word
//  m_gen2_mode     in   1   carried for link compatibility; no functional effect
//  rd_cnt_err      out  1   sticky: RLAST handshake with read count 0
//  wr_cnt_err      out  1   sticky: B handshake with write count 0
// BEHAVIOUR
//  Bit packing (LSB first):
//   AR/AW = {addr[46:15], burst[14:13], len[12:5], size[4:2], id[1:0]}
//   W = {last[38], strb[37:34], data[33:2], id[1:0]}
//   R = {resp[36:35], last[34], data[33:2], id[1:0]}
//   B = {resp[3:2], id[1:0]}
//  Skid buffer (one per channel, 2 entries, FIFO order):
//   in_ready = (entries<2) & ~rst_q, where rst_q is a flop set in reset and cleared 1 cycle later.
//   Push on in_valid&in_ready; pop on out_valid&out_ready; push+pop together keeps the entry count.
//   out_valid = entries!=0; out data is the head entry, stable while out_valid&~out_ready.
//   Latency: a word pushed in cycle N is visible at the output in N+1.
//   Full throughput: 1 word/cycle when the downstream ready is held high.
//  Outstanding gating:
//   user_arready = ar_in_ready & (rd_cnt < MAX_RD_OUT).
//   user_awready = aw_in_ready & (wr_cnt < MAX_WR_OUT).
//   rd_cnt +1 on AR user handshake; -1 on user_rvalid&user_rready&user_rlast; both together = hold.
//   wr_cnt +1 on AW user handshake; -1 on user_bvalid&user_bready; both together = hold.
//   A decrement at 0 does not wrap: the count stays 0 and the matching *_cnt_err sets.
//   Counter width is $clog2(MAX+1). W is never gated by the counters.
//  Reset (rst_wr_n low at a clock edge):
//   All buffers empty; rd_cnt=wr_cnt=0; errors=0; all valids=0; all readies=0.
//   In-flight data is discarded, including mid-burst. Readies rise in the 2nd cycle after release.
// TESTING
//  1. Single AR id=1 size=2 len=3 burst=1 addr=0x1000, link ready=1 -> txfifo_ar_data=0x0000_0800_2069 one cycle later, rd_cnt=1.
//  2. 10 back-to-back ARs, MAX_RD_OUT=8, no R returned -> exactly 8 accepted, user_arready=0; one RLAST beat -> 9th accepted next cycle.
//  3. W stream of 16 beats, user_w_ready toggling 1/0 each cycle -> all 16 beats delivered in order, none dropped/duplicated, data stable while stalled.
//  4. R burst of 4 beats, rresp=0, user_rready=0 for 3 cycles -> user_r_ready falls after 2 buffered words; beats emerge in order, rd_cnt drops by 1 only at RLAST.
//  5. B arrives with wr_cnt=0 -> wr_cnt stays 0, wr_cnt_err=1 and remains 1 until reset.
//  6. Assert rst_wr_n=0 while 2 AW words are buffered and wr_cnt=5 -> next cycle valids=0, wr_cnt=0; readies=0 until 2nd cycle after release.

Source files
------------

// File: rtl/axi_mm_master_name_reg.sv
// Master-side AXI4-MM <-> link bridge: packs AR/AW/W into link words and unpacks R/B onto user AXI.
// Latency: 1 cycle per channel through a 2-entry registered skid buffer.
// Backpressure: per-channel ready drops when its buffer holds 2 words; AR/AW also stall at the outstanding cap.

module axi_mm_master_name_reg_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rst_q,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic [1:0]   cnt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_rdy  = (cnt != 2'd2) & ~rst_q;
    assign out_vld = (cnt != 2'd0);
    assign out_dat = head;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is always the oldest word; tail only fills when head is occupied and not leaving.
    always_ff @(posedge clk) begin
        if (pop && cnt == 2'd2)
            head <= tail;
        else if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
            head <= in_dat;
        if (push && cnt == 2'd1 && !pop)
            tail <= in_dat;
    end
endmodule

module axi_mm_master_name_reg #(
    parameter int MAX_RD_OUT = 8,
    parameter int MAX_WR_OUT = 8
) (
    input  logic        clk_wr,
    input  logic        rst_wr_n,
    input  logic [1:0]  user_arid,
    input  logic [2:0]  user_arsize,
    input  logic [7:0]  user_arlen,
    input  logic [1:0]  user_arburst,
    input  logic [31:0] user_araddr,
    input  logic        user_arvalid,
    output logic        user_arready,
    input  logic [1:0]  user_awid,
    input  logic [2:0]  user_awsize,
    input  logic [7:0]  user_awlen,
    input  logic [1:0]  user_awburst,
    input  logic [31:0] user_awaddr,
    input  logic        user_awvalid,
    output logic        user_awready,
    input  logic [1:0]  user_wid,
    input  logic [31:0] user_wdata,
    input  logic [3:0]  user_wstrb,
    input  logic        user_wlast,
    input  logic        user_wvalid,
    output logic        user_wready,
    output logic [1:0]  user_rid,
    output logic [31:0] user_rdata,
    output logic        user_rlast,
    output logic [1:0]  user_rresp,
    output logic        user_rvalid,
    input  logic        user_rready,
    output logic [1:0]  user_bid,
    output logic [1:0]  user_bresp,
    output logic        user_bvalid,
    input  logic        user_bready,
    output logic        user_ar_vld,
    output logic [46:0] txfifo_ar_data,
    input  logic        user_ar_ready,
    output logic        user_aw_vld,
    output logic [46:0] txfifo_aw_data,
    input  logic        user_aw_ready,
    output logic        user_w_vld,
    output logic [38:0] txfifo_w_data,
    input  logic        user_w_ready,
    input  logic        user_r_vld,
    input  logic [36:0] rxfifo_r_data,
    output logic        user_r_ready,
    input  logic        user_b_vld,
    input  logic [3:0]  rxfifo_b_data,
    output logic        user_b_ready,
    input  logic        m_gen2_mode,
    output logic        rd_cnt_err,
    output logic        wr_cnt_err
);
    localparam int RCW = $clog2(MAX_RD_OUT + 1);
    localparam int WCW = $clog2(MAX_WR_OUT + 1);
    localparam logic [RCW-1:0] RD_LIM = RCW'(MAX_RD_OUT);
    localparam logic [WCW-1:0] WR_LIM = WCW'(MAX_WR_OUT);
    localparam logic [RCW-1:0] RD_ONE = RCW'(1);
    localparam logic [WCW-1:0] WR_ONE = WCW'(1);

    logic           rst_q;
    logic [RCW-1:0] rd_cnt;
    logic [WCW-1:0] wr_cnt;
    logic           rd_ok, wr_ok;
    logic           ar_in_rdy, aw_in_rdy;
    logic           rd_inc, rd_dec, wr_inc, wr_dec;
    logic [36:0]    r_out_dat;
    logic [3:0]     b_out_dat;
    logic           unused_gen2;

    assign unused_gen2 = m_gen2_mode;

    // Holds every ready low for the first cycle after reset release.
    always_ff @(posedge clk_wr) rst_q <= ~rst_wr_n;

    assign rd_ok        = (rd_cnt < RD_LIM);
    assign wr_ok        = (wr_cnt < WR_LIM);
    assign user_arready = ar_in_rdy & rd_ok;
    assign user_awready = aw_in_rdy & wr_ok;

    assign rd_inc = user_arvalid & user_arready;
    assign rd_dec = user_rvalid & user_rready & user_rlast;
    assign wr_inc = user_awvalid & user_awready;
    assign wr_dec = user_bvalid & user_bready;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            rd_cnt     <= '0;
            rd_cnt_err <= 1'b0;
        end else if (rd_inc && !rd_dec) begin
            rd_cnt <= rd_cnt + RD_ONE;
        end else if (rd_dec && !rd_inc) begin
            if (rd_cnt == '0) rd_cnt_err <= 1'b1;
            else              rd_cnt     <= rd_cnt - RD_ONE;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            wr_cnt     <= '0;
            wr_cnt_err <= 1'b0;
        end else if (wr_inc && !wr_dec) begin
            wr_cnt <= wr_cnt + WR_ONE;
        end else if (wr_dec && !wr_inc) begin
            if (wr_cnt == '0) wr_cnt_err <= 1'b1;
            else              wr_cnt     <= wr_cnt - WR_ONE;
        end
    end

    axi_mm_master_name_reg_skid #(.W(47)) u_ar (
        .clk(clk_wr), .rst_n(rst_wr_n), .rst_q(rst_q),
        .in_vld(user_arvalid & rd_ok), .in_rdy(ar_in_rdy),
        .in_dat({user_araddr, user_arburst, user_arlen, user_arsize, user_arid}),
        .out_vld(user_ar_vld), .out_rdy(user_ar_ready), .out_dat(txfifo_ar_data)
    );

    axi_mm_master_name_reg_skid #(.W(47)) u_aw (
        .clk(clk_wr), .rst_n(rst_wr_n), .rst_q(rst_q),
        .in_vld(user_awvalid & wr_ok), .in_rdy(aw_in_rdy),
        .in_dat({user_awaddr, user_awburst, user_awlen, user_awsize, user_awid}),
        .out_vld(user_aw_vld), .out_rdy(user_aw_ready), .out_dat(txfifo_aw_data)
    );

    axi_mm_master_name_reg_skid #(.W(39)) u_w (
        .clk(clk_wr), .rst_n(rst_wr_n), .rst_q(rst_q),
        .in_vld(user_wvalid), .in_rdy(user_wready),
        .in_dat({user_wlast, user_wstrb, user_wdata, user_wid}),
        .out_vld(user_w_vld), .out_rdy(user_w_ready), .out_dat(txfifo_w_data)
    );

    axi_mm_master_name_reg_skid #(.W(37)) u_r (
        .clk(clk_wr), .rst_n(rst_wr_n), .rst_q(rst_q),
        .in_vld(user_r_vld), .in_rdy(user_r_ready), .in_dat(rxfifo_r_data),
        .out_vld(user_rvalid), .out_rdy(user_rready), .out_dat(r_out_dat)
    );

    axi_mm_master_name_reg_skid #(.W(4)) u_b (
        .clk(clk_wr), .rst_n(rst_wr_n), .rst_q(rst_q),
        .in_vld(user_b_vld), .in_rdy(user_b_ready), .in_dat(rxfifo_b_data),
        .out_vld(user_bvalid), .out_rdy(user_bready), .out_dat(b_out_dat)
    );

    assign {user_rresp, user_rlast, user_rdata, user_rid} = r_out_dat;
    assign {user_bresp, user_bid} = b_out_dat;
endmodule

// File: tb/tb_axi_mm_master_name_reg.sv
// Scoreboard bench for axi_mm_master_name_reg: stimulus queues expected link/user words,
// a negedge monitor pops and compares on every output handshake.
module tb_axi_mm_master_name_reg;
    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic [1:0]  user_arid, user_arburst, user_awid, user_awburst, user_wid;
    logic [2:0]  user_arsize, user_awsize;
    logic [7:0]  user_arlen, user_awlen;
    logic [31:0] user_araddr, user_awaddr, user_wdata;
    logic        user_arvalid, user_arready, user_awvalid, user_awready;
    logic [3:0]  user_wstrb;
    logic        user_wlast, user_wvalid, user_wready;
    logic [1:0]  user_rid, user_rresp, user_bid, user_bresp;
    logic [31:0] user_rdata;
    logic        user_rlast, user_rvalid, user_rready, user_bvalid, user_bready;
    logic        user_ar_vld, user_ar_ready, user_aw_vld, user_aw_ready, user_w_vld, user_w_ready;
    logic [46:0] txfifo_ar_data, txfifo_aw_data;
    logic [38:0] txfifo_w_data;
    logic        user_r_vld, user_r_ready, user_b_vld, user_b_ready;
    logic [36:0] rxfifo_r_data;
    logic [3:0]  rxfifo_b_data;
    logic        m_gen2_mode, rd_cnt_err, wr_cnt_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_ar[$], exp_aw[$], exp_w[$], exp_r[$], exp_b[$];
    logic        w_hold = 1'b0;
    logic [38:0] w_held;

    always #5 clk_wr = ~clk_wr;

    axi_mm_master_name_reg #(.MAX_RD_OUT(8), .MAX_WR_OUT(8)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
        .user_arburst(user_arburst), .user_araddr(user_araddr),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
        .user_awburst(user_awburst), .user_awaddr(user_awaddr),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
        .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready),
        .user_ar_vld(user_ar_vld), .txfifo_ar_data(txfifo_ar_data), .user_ar_ready(user_ar_ready),
        .user_aw_vld(user_aw_vld), .txfifo_aw_data(txfifo_aw_data), .user_aw_ready(user_aw_ready),
        .user_w_vld(user_w_vld), .txfifo_w_data(txfifo_w_data), .user_w_ready(user_w_ready),
        .user_r_vld(user_r_vld), .rxfifo_r_data(rxfifo_r_data), .user_r_ready(user_r_ready),
        .user_b_vld(user_b_vld), .rxfifo_b_data(rxfifo_b_data), .user_b_ready(user_b_ready),
        .m_gen2_mode(m_gen2_mode), .rd_cnt_err(rd_cnt_err), .wr_cnt_err(wr_cnt_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected handshake expected none at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [63:0] pack_a(input logic [1:0] id, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst,
                                           input logic [31:0] addr);
        return 64'({addr, burst, len, size, id});
    endfunction

    function automatic logic [63:0] pack_w(input logic [1:0] id, input logic [31:0] data,
                                           input logic [3:0] strb, input logic last);
        return 64'({last, strb, data, id});
    endfunction

    function automatic logic [36:0] pack_r(input logic [1:0] resp, input logic last,
                                           input logic [31:0] data, input logic [1:0] id);
        return {resp, last, data, id};
    endfunction

    // Monitor: every handshake on an output channel must match the oldest expected word.
    always @(negedge clk_wr) begin
        if (rst_wr_n) begin
            if (user_ar_vld && user_ar_ready) begin
                if (exp_ar.size() == 0) unexpected("ar_link");
                else chk("ar_link", 64'(txfifo_ar_data), exp_ar.pop_front());
            end
            if (user_aw_vld && user_aw_ready) begin
                if (exp_aw.size() == 0) unexpected("aw_link");
                else chk("aw_link", 64'(txfifo_aw_data), exp_aw.pop_front());
            end
            if (user_w_vld && user_w_ready) begin
                if (exp_w.size() == 0) unexpected("w_link");
                else chk("w_link", 64'(txfifo_w_data), exp_w.pop_front());
            end
            if (user_rvalid && user_rready) begin
                if (exp_r.size() == 0) unexpected("r_user");
                else chk("r_user", 64'({user_rresp, user_rlast, user_rdata, user_rid}), exp_r.pop_front());
            end
            if (user_bvalid && user_bready) begin
                if (exp_b.size() == 0) unexpected("b_user");
                else chk("b_user", 64'({user_bresp, user_bid}), exp_b.pop_front());
            end
            if (w_hold && user_w_vld) chk("w_stable", 64'(txfifo_w_data), 64'(w_held));
            w_hold = user_w_vld && !user_w_ready;
            w_held = txfifo_w_data;
        end else begin
            w_hold = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, wb, rb;
        rst_wr_n = 1'b0; m_gen2_mode = 1'b0;
        user_arid = '0; user_arsize = '0; user_arlen = '0; user_arburst = '0; user_araddr = '0;
        user_arvalid = 1'b0;
        user_awid = '0; user_awsize = '0; user_awlen = '0; user_awburst = '0; user_awaddr = '0;
        user_awvalid = 1'b0;
        user_wid = '0; user_wdata = '0; user_wstrb = '0; user_wlast = 1'b0; user_wvalid = 1'b0;
        user_rready = 1'b1; user_bready = 1'b1;
        user_ar_ready = 1'b1; user_aw_ready = 1'b1; user_w_ready = 1'b1;
        user_r_vld = 1'b0; rxfifo_r_data = '0; user_b_vld = 1'b0; rxfifo_b_data = '0;

        // Reset state and ready release timing
        repeat (3) tick();
        chk("rst_valids", 64'({user_ar_vld, user_aw_vld, user_w_vld, user_rvalid, user_bvalid}), 0);
        chk("rst_readies", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 0);
        chk("rst_cnts", 64'({dut.rd_cnt, dut.wr_cnt}), 0);
        chk("rst_errs", 64'({rd_cnt_err, wr_cnt_err}), 0);
        rst_wr_n = 1'b1;
        chk("rel_readies_c1", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 0);
        tick();
        chk("rel_readies_c2", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 64'h1f);

        // Single AR packing and one-cycle latency
        user_arid = 2'd1; user_arsize = 3'd2; user_arlen = 8'd3; user_arburst = 2'd1;
        user_araddr = 32'h1000; user_arvalid = 1'b1;
        chk("ar_rdy_t1", 64'(user_arready), 1);
        exp_ar.push_back(64'h0000_0800_2069);
        tick();
        user_arvalid = 1'b0;
        chk("ar_vld_lat", 64'(user_ar_vld), 1);
        chk("rd_cnt_t1", 64'(dut.rd_cnt), 1);
        tick();

        // R burst of 4 with user stalled for 3 cycles
        user_rready = 1'b0;
        rb = 0;
        for (int c = 0; c < 3; c++) begin
            user_r_vld = 1'b1;
            rxfifo_r_data = pack_r(2'd0, rb == 3, 32'hA0 + rb, 2'd1);
            if (user_r_ready) begin exp_r.push_back(64'(rxfifo_r_data)); rb++; end
            tick();
        end
        chk("r_link_full", 64'(user_r_ready), 0);
        chk("r_accepted", 64'(rb), 2);
        chk("rd_cnt_stall", 64'(dut.rd_cnt), 1);
        user_rready = 1'b1;
        for (int c = 0; c < 20 && rb < 4; c++) begin
            user_r_vld = 1'b1;
            rxfifo_r_data = pack_r(2'd0, rb == 3, 32'hA0 + rb, 2'd1);
            if (user_r_ready) begin exp_r.push_back(64'(rxfifo_r_data)); rb++; end
            tick();
        end
        user_r_vld = 1'b0;
        chk("rd_cnt_pre_last", 64'(dut.rd_cnt), 1);
        tick();
        chk("rd_cnt_post_last", 64'(dut.rd_cnt), 0);
        tick();

        // Outstanding read cap
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            user_arid = 2'(acc); user_arsize = 3'd2; user_arlen = 8'd0; user_arburst = 2'd1;
            user_araddr = 32'h2000 + 32'(acc) * 16; user_arvalid = 1'b1;
            if (user_arready) begin
                exp_ar.push_back(pack_a(2'(acc), 3'd2, 8'd0, 2'd1, 32'h2000 + 32'(acc) * 16));
                acc++;
            end
            tick();
        end
        chk("ar_accepted", 64'(acc), 8);
        chk("ar_rdy_capped", 64'(user_arready), 0);
        chk("rd_cnt_cap", 64'(dut.rd_cnt), 8);
        user_r_vld = 1'b1; rxfifo_r_data = pack_r(2'd0, 1'b1, 32'hDEAD_0001, 2'd0);
        exp_r.push_back(64'(rxfifo_r_data));
        tick();
        user_r_vld = 1'b0;
        chk("ar_rdy_before_rlast", 64'(user_arready), 0);
        tick();
        chk("rd_cnt_after_rlast", 64'(dut.rd_cnt), 7);
        chk("ar_rdy_after_rlast", 64'(user_arready), 1);
        exp_ar.push_back(pack_a(2'd0, 3'd2, 8'd0, 2'd1, 32'h2080));
        tick();
        user_arvalid = 1'b0;
        chk("rd_cnt_9th", 64'(dut.rd_cnt), 8);
        tick();

        // W stream with toggling link ready
        wb = 0;
        user_w_ready = 1'b0;
        for (int c = 0; c < 100 && wb < 16; c++) begin
            user_w_ready = ~user_w_ready;
            user_wvalid = 1'b1; user_wid = 2'd2; user_wdata = 32'h1111_0000 + wb;
            user_wstrb = 4'hF ^ 4'(wb); user_wlast = (wb % 4 == 3);
            if (user_wready) begin
                exp_w.push_back(pack_w(2'd2, 32'h1111_0000 + wb, 4'hF ^ 4'(wb), wb % 4 == 3));
                wb++;
            end
            tick();
        end
        user_wvalid = 1'b0;
        for (int c = 0; c < 20 && exp_w.size() != 0; c++) begin
            user_w_ready = ~user_w_ready;
            tick();
        end
        user_w_ready = 1'b1;
        chk("w_count", 64'(wb), 16);
        chk("w_drained", 64'(exp_w.size()), 0);

        // B with no outstanding writes
        user_b_vld = 1'b1; rxfifo_b_data = 4'b1011;
        exp_b.push_back(64'h b);
        tick();
        user_b_vld = 1'b0;
        tick();
        chk("wr_cnt_no_wrap", 64'(dut.wr_cnt), 0);
        chk("wr_err_set", 64'(wr_cnt_err), 1);
        repeat (3) tick();
        chk("wr_err_sticky", 64'(wr_cnt_err), 1);
        chk("rd_err_clear", 64'(rd_cnt_err), 0);

        // Reset with AW words buffered and wr_cnt=5
        for (int i = 0; i < 5; i++) begin
            if (i == 3) user_aw_ready = 1'b0;
            user_awid = 2'(i); user_awsize = 3'd2; user_awlen = 8'd1; user_awburst = 2'd1;
            user_awaddr = 32'h3000 + 32'(i) * 8; user_awvalid = 1'b1;
            chk("aw_rdy", 64'(user_awready), 1);
            if (i < 3) exp_aw.push_back(pack_a(2'(i), 3'd2, 8'd1, 2'd1, 32'h3000 + 32'(i) * 8));
            tick();
            if (i == 2) begin user_awvalid = 1'b0; tick(); tick(); end
        end
        user_awvalid = 1'b0;
        chk("wr_cnt_5", 64'(dut.wr_cnt), 5);
        chk("aw_buf_full", 64'({user_aw_vld, user_awready}), 64'b10);
        rst_wr_n = 1'b0;
        tick();
        user_aw_ready = 1'b1;
        chk("rst2_valids", 64'({user_ar_vld, user_aw_vld, user_w_vld, user_rvalid, user_bvalid}), 0);
        chk("rst2_cnts", 64'({dut.rd_cnt, dut.wr_cnt}), 0);
        chk("rst2_errs", 64'({rd_cnt_err, wr_cnt_err}), 0);
        chk("rst2_readies", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 0);
        rst_wr_n = 1'b1;
        chk("rel2_readies_c1", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 0);
        tick();
        chk("rel2_readies_c2", 64'({user_arready, user_awready, user_wready, user_r_ready, user_b_ready}), 64'h1f);
        repeat (3) tick();
        chk("aw_discarded", 64'(user_aw_vld), 0);
        chk("sb_empty", 64'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
